keypad_scan_fifo: RTL and testbench
===================================

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 Parameter NUM_COLS, default 3: number of scanned columns; legal range 2..8.
REQ-002 Parameter NUM_ROWS, default 4: number of row return lines; legal range 2..8.
REQ-003 Parameter SCAN_DIV, default 250000: clocks per column dwell; minimum 4.
REQ-004 Parameter DEBOUNCE_SCANS, default 3: consecutive identical frames required for press and for release; minimum 2.
REQ-005 Parameter FIFO_DEPTH, default 4: key-event queue depth; power of 2, minimum 2.
REQ-006 Derived constant CW = clog2(NUM_COLS*NUM_ROWS): key code width.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 column_sel  output  NUM_COLS  one-hot active-high column drive.
REQ-010 scan_data  input  NUM_ROWS  active-high row returns, asynchronous to clk.
REQ-011 key_code  output  CW  code at FIFO head.
REQ-012 key_valid  output  1  FIFO non-empty.
REQ-013 key_ready  input  1  consumer pop strobe.
REQ-014 key_held  output  1  debounced key currently held.
REQ-015 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 scan_data SHALL pass through a two-flop synchronizer before any use.
REQ-017 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; column_sel SHALL rotate to the next column (NUM_COLS-1 wraps to 0) on the wrap cycle.
REQ-018 Synchronized rows SHALL be sampled for the active column on the wrap cycle only (dwell end, settled).
REQ-019 Key code SHALL be col*NUM_ROWS + row; if multiple keys are active in a frame, the lowest code wins; no key = NONE.
REQ-020 A frame SHALL end on the wrap cycle of column NUM_COLS-1, producing a one-cycle frame_done and the frame code.
REQ-021 Debounce FSM states: IDLE, CANDIDATE, HELD; it SHALL update only on frame_done.
REQ-022 IDLE: non-NONE frame -> CANDIDATE, cand=code, count=1; NONE -> stay.
REQ-023 CANDIDATE: same code -> count+1, and at count==DEBOUNCE_SCANS -> HELD with push of cand; different non-NONE -> restart, count=1; NONE -> IDLE.
REQ-024 HELD: NONE frame -> release count+1, at DEBOUNCE_SCANS -> IDLE; any non-NONE frame clears release count; other codes do not generate events.
REQ-025 key_held SHALL be 1 exactly while the FSM is in HELD.
REQ-026 Push latency: key_valid and key_code SHALL be visible in the cycle after frame_done that completes debounce.
REQ-027 Pop SHALL occur on a cycle with key_valid=1 and key_ready=1; key_ready while empty SHALL be ignored.
REQ-028 Push while full without pop SHALL drop the new event and set overflow; overflow SHALL stay 1 until reset.
REQ-029 Simultaneous push and pop while full SHALL perform both with no overflow; while empty, push SHALL proceed and the pop SHALL be ignored.
REQ-030 key_code SHALL read 0 when the FIFO is empty.

Reset
REQ-031 On rst: column_sel=one-hot column 0, dwell counter=0, synchronizer=0, FSM=IDLE, counts=0, FIFO empty, key_valid=0, key_code=0, key_held=0, overflow=0.
REQ-032 Reset mid-debounce or mid-scan SHALL discard all in-flight state; scanning restarts at column 0 in the cycle after rst deasserts.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state enumeration, the NONE code encoding and the code-width function.
REQ-034 The queue SHALL be sub-module key_event_fifo (parameters depth and width, push/pop/full/empty); scanner and FSM reside in keypad_scan_fifo.

Verification (NUM_COLS=3, NUM_ROWS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; frame = 12 clocks)
REQ-035 Hold col1,row2 for 4 frames -> key_valid=1, key_code=6 in the cycle after the 3rd frame_done; key_held=1; pop -> key_valid=0.
REQ-036 Bounce: key 6 present on alternate frames for 10 frames -> no event, key_held=0.
REQ-037 Col0,row3 and col2,row0 held together -> single event, key_code=3.
REQ-038 Five distinct debounced presses (codes 1,2,5,7,9) with no pop -> FIFO holds 1,2,5,7; overflow=1; pops return 1,2,5,7 in order.
REQ-039 FIFO full with key_ready=1 on the push cycle -> no overflow, entry count stays 4.
REQ-040 rst pulsed while in CANDIDATE count=2 -> all outputs at reset values; key must then be stable 3 new frames before an event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce states, the NONE frame
// code and the key-code width helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CANDIDATE,
      HELD
   } deb_state_t;

   // Frame codes carry one spare bit so NONE never aliases a real key.
   localparam int CODE_W = 7;
   localparam logic [CODE_W-1:0] NONE_CODE = '1;

   function automatic int code_width(input int keys);
      return (keys <= 2) ? 1 : $clog2(keys);
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small circular queue for debounced key events.
// Head reads zero while empty.
module key_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot a full queue needs.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Column-scanning keypad reader with frame debounce and an event queue.
// Codes are col*NUM_ROWS + row; lowest active code wins a frame.
module keypad_scan_fifo
   import keypad_pkg::*;
#(
   parameter int NUM_COLS       = 3,
   parameter int NUM_ROWS       = 4,
   parameter int SCAN_DIV       = 250000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int CW             = code_width(NUM_COLS * NUM_ROWS)
) (
   input  logic                clk,
   input  logic                rst,
   output logic [NUM_COLS-1:0] column_sel,
   input  logic [NUM_ROWS-1:0] scan_data,
   output logic [CW-1:0]       key_code,
   output logic                key_valid,
   input  logic                key_ready,
   output logic                key_held,
   output logic                overflow
);

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int CIW = $clog2(NUM_COLS);
   localparam int CNW = $clog2(DEBOUNCE_SCANS + 1);

   logic [NUM_ROWS-1:0] sync1;
   logic [NUM_ROWS-1:0] sync2;
   logic [DW-1:0]       dwell;
   logic [CIW-1:0]      col_idx;
   logic                wrap;
   logic                last_col;
   logic [CODE_W-1:0]   col_code;
   logic [CODE_W-1:0]   frame_acc;
   logic [CODE_W-1:0]   acc_next;
   logic [CODE_W-1:0]   frame_code;
   logic                frame_done;

   deb_state_t          state;
   logic [CODE_W-1:0]   cand;
   logic [CNW-1:0]      cnt;
   logic [CNW-1:0]      rel_cnt;
   logic                push;
   logic                full;
   logic                empty;

   assign wrap     = (dwell == DW'(SCAN_DIV - 1));
   assign last_col = (col_idx == CIW'(NUM_COLS - 1));

   always_comb begin
      col_code = NONE_CODE;
      for (int r = NUM_ROWS - 1; r >= 0; r--)
         if (sync2[r])
            col_code = CODE_W'(int'(col_idx) * NUM_ROWS + r);
   end

   // Columns are visited in ascending order, so the first hit is lowest.
   assign acc_next = (frame_acc == NONE_CODE) ? col_code : frame_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         dwell      <= '0;
         col_idx    <= '0;
         column_sel <= NUM_COLS'(1);
         frame_acc  <= NONE_CODE;
         frame_code <= NONE_CODE;
         frame_done <= 1'b0;
      end else begin
         sync1      <= scan_data;
         sync2      <= sync1;
         frame_done <= 1'b0;
         if (wrap) begin
            dwell      <= '0;
            column_sel <= {column_sel[NUM_COLS-2:0],
                           column_sel[NUM_COLS-1]};
            if (last_col) begin
               col_idx    <= '0;
               frame_code <= acc_next;
               frame_done <= 1'b1;
               frame_acc  <= NONE_CODE;
            end else begin
               col_idx   <= col_idx + 1'b1;
               frame_acc <= acc_next;
            end
         end else begin
            dwell <= dwell + 1'b1;
         end
      end
   end

   assign push = frame_done
              && (state == CANDIDATE)
              && (frame_code == cand)
              && (cnt == CNW'(DEBOUNCE_SCANS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cand    <= NONE_CODE;
         cnt     <= '0;
         rel_cnt <= '0;
      end else if (frame_done) begin
         unique case (state)
            IDLE: begin
               if (frame_code != NONE_CODE) begin
                  state <= CANDIDATE;
                  cand  <= frame_code;
                  cnt   <= CNW'(1);
               end
            end
            CANDIDATE: begin
               if (frame_code == NONE_CODE) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (frame_code != cand) begin
                  cand <= frame_code;
                  cnt  <= CNW'(1);
               end else if (push) begin
                  state   <= HELD;
                  cnt     <= '0;
                  rel_cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (frame_code != NONE_CODE) begin
                  rel_cnt <= '0;
               end else if (rel_cnt == CNW'(DEBOUNCE_SCANS - 1)) begin
                  state   <= IDLE;
                  rel_cnt <= '0;
               end else begin
                  rel_cnt <= rel_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign key_held  = (state == HELD);
   assign key_valid = ~empty;

   // A full queue only has room when the consumer pops the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         overflow <= 1'b0;
      else if (push && full && !key_ready)
         overflow <= 1'b1;
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CW)
   ) fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (key_ready),
      .din   (cand[CW-1:0]),
      .dout  (key_code),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a behavioural keypad matrix
// and an expected-event queue checked at every consumer pop.
module tb_keypad_scan_fifo;

   localparam int NC = 3;
   localparam int NR = 4;

   logic          clk;
   logic          rst;
   logic [NC-1:0] column_sel;
   logic [NR-1:0] scan_data;
   logic [3:0]    key_code;
   logic          key_valid;
   logic          key_ready;
   logic          key_held;
   logic          overflow;

   logic [NC*NR-1:0] pressed;
   int               exp_q[$];
   int               tests = 0;
   int               fails = 0;

   keypad_scan_fifo #(
      .NUM_COLS       (NC),
      .NUM_ROWS       (NR),
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .column_sel (column_sel),
      .scan_data  (scan_data),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_held   (key_held),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key returns its row while its column is driven.
   always_comb begin
      scan_data = '0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            if (column_sel[c] && pressed[c*NR + r])
               scan_data[r] = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge of the first cycle of a new frame.
   task automatic wait_frame_start();
      bit            found;
      logic [NC-1:0] prev;
      found = 1'b0;
      prev  = column_sel;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (prev == 3'b100 && column_sel == 3'b001)
            found = 1'b1;
         prev = column_sel;
      end
      if (!found)
         chk("frame_align_timeout", 0, 1);
   endtask

   task automatic wait_valid(input string tag, input int limit);
      bit found;
      found = key_valid;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         found = key_valid;
      end
      if (!found)
         chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic pop_check(input string tag);
      int exp;
      wait_valid(tag, 100);
      if (key_valid) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, key_valid, 0);
         end else begin
            exp = exp_q.pop_front();
            chk(tag, key_code, exp);
         end
         key_ready = 1'b1;
         @(negedge clk);
         key_ready = 1'b0;
      end
   endtask

   task automatic press(input int code, input bit expect_evt);
      pressed       = '0;
      pressed[code] = 1'b1;
      if (expect_evt)
         exp_q.push_back(code);
      cycles(72);
      pressed = '0;
      cycles(72);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      key_ready = 1'b0;
      pressed   = '0;
      cycles(3);
      chk("rst_column_sel", column_sel, 1);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_key_held", key_held, 0);
      chk("rst_overflow", overflow, 0);

      rst = 1'b0;
      cycles(1);
      chk("scan_col0_start", column_sel, 1);
      cycles(2);
      chk("scan_col0_dwell_end", column_sel, 1);
      cycles(1);
      chk("scan_col1", column_sel, 2);
      cycles(72);

      // Frame-aligned press of key 6 checks exact push latency.
      wait_frame_start();
      pressed[6] = 1'b1;
      exp_q.push_back(6);
      wait_frame_start();
      wait_frame_start();
      wait_frame_start();
      chk("latency_not_early", key_valid, 0);
      chk("held_not_early", key_held, 0);
      cycles(1);
      chk("latency_valid", key_valid, 1);
      chk("latency_code", key_code, 6);
      chk("held_on", key_held, 1);
      pop_check("pop_key6");
      chk("empty_after_pop", key_valid, 0);
      chk("empty_code_zero", key_code, 0);
      pressed = '0;
      cycles(72);
      chk("held_off", key_held, 0);

      for (int i = 0; i < 10; i++) begin
         pressed[6] = (i % 2 == 0);
         cycles(12);
         chk("bounce_held", key_held, 0);
      end
      pressed = '0;
      cycles(48);
      chk("bounce_no_event", key_valid, 0);

      pressed[3] = 1'b1;
      pressed[8] = 1'b1;
      exp_q.push_back(3);
      pop_check("pop_multi");
      cycles(36);
      chk("multi_single_event", key_valid, 0);
      pressed = '0;
      cycles(72);

      press(1, 1'b1);
      press(2, 1'b1);
      press(5, 1'b1);
      press(7, 1'b1);
      chk("full_no_overflow", overflow, 0);
      press(9, 1'b0);
      chk("overflow_set", overflow, 1);
      chk("overflow_valid", key_valid, 1);
      pop_check("ovf_pop0");
      pop_check("ovf_pop1");
      pop_check("ovf_pop2");
      pop_check("ovf_pop3");
      chk("ovf_drained", key_valid, 0);
      chk("overflow_sticky", overflow, 1);

      do_reset();
      chk("overflow_cleared", overflow, 0);
      press(1, 1'b1);
      press(2, 1'b1);
      press(5, 1'b1);
      press(7, 1'b1);
      wait_frame_start();
      pressed[9] = 1'b1;
      wait_frame_start();
      wait_frame_start();
      wait_frame_start();
      chk("full_head", key_code, exp_q.pop_front());
      exp_q.push_back(9);
      key_ready = 1'b1;
      cycles(1);
      key_ready = 1'b0;
      chk("push_pop_full_no_ovf", overflow, 0);
      pressed = '0;
      cycles(72);
      pop_check("pp_pop0");
      pop_check("pp_pop1");
      pop_check("pp_pop2");
      pop_check("pp_pop3");
      chk("pp_four_entries", key_valid, 0);

      // Reset while a candidate has two matching frames.
      wait_frame_start();
      pressed[4] = 1'b1;
      wait_frame_start();
      wait_frame_start();
      cycles(1);
      rst = 1'b1;
      cycles(1);
      chk("mid_rst_column_sel", column_sel, 1);
      chk("mid_rst_key_valid", key_valid, 0);
      chk("mid_rst_key_code", key_code, 0);
      chk("mid_rst_key_held", key_held, 0);
      chk("mid_rst_overflow", overflow, 0);
      rst = 1'b0;
      exp_q.push_back(4);
      cycles(30);
      chk("mid_rst_no_early", key_valid, 0);
      pop_check("mid_rst_pop");
      chk("mid_rst_drained", key_valid, 0);
      pressed = '0;
      cycles(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
